// File: rtl/pito_mvu_dispatch_pkg.sv
// Shared types and constants for the per-hart MVU job dispatcher.
package pito_mvu_dispatch_pkg;

   localparam int unsigned NUM_HARTS = 8;
   localparam int unsigned CSR_W     = 32;
   localparam int unsigned HART_ID_W = $clog2(NUM_HARTS);

   // Snapshot of one hart's MVU CSR block; wbaseaddr sits at the MSB end.
   typedef struct packed {
      logic [CSR_W-1:0] wbaseaddr;
      logic [CSR_W-1:0] ibaseaddr;
      logic [CSR_W-1:0] obaseaddr;
      logic [CSR_W-1:0] wstride_0;
      logic [CSR_W-1:0] wstride_1;
      logic [CSR_W-1:0] wstride_2;
      logic [CSR_W-1:0] wstride_3;
      logic [CSR_W-1:0] istride_0;
      logic [CSR_W-1:0] istride_1;
      logic [CSR_W-1:0] istride_2;
      logic [CSR_W-1:0] istride_3;
      logic [CSR_W-1:0] ostride_0;
      logic [CSR_W-1:0] ostride_1;
      logic [CSR_W-1:0] ostride_2;
      logic [CSR_W-1:0] ostride_3;
      logic [CSR_W-1:0] wlength_0;
      logic [CSR_W-1:0] wlength_1;
      logic [CSR_W-1:0] wlength_2;
      logic [CSR_W-1:0] wlength_3;
      logic [CSR_W-1:0] ilength_0;
      logic [CSR_W-1:0] ilength_1;
      logic [CSR_W-1:0] ilength_2;
      logic [CSR_W-1:0] ilength_3;
      logic [CSR_W-1:0] olength_0;
      logic [CSR_W-1:0] olength_1;
      logic [CSR_W-1:0] olength_2;
      logic [CSR_W-1:0] olength_3;
      logic [CSR_W-1:0] precision;
      logic [CSR_W-1:0] command;
      logic [CSR_W-1:0] quant;
   } mvu_job_t;

   localparam int unsigned MVU_JOB_W = $bits(mvu_job_t);

   typedef enum logic [1:0] {IDLE, PENDING, ISSUED} mvu_slot_state_e;

endpackage

// File: rtl/pito_mvu_dispatch_if.sv
// MVU job port plus the per-hart CSR buses feeding the dispatcher.
interface pito_mvu_dispatch_if;
   import pito_mvu_dispatch_pkg::*;

   localparam int unsigned CW = CSR_W * NUM_HARTS;

   logic                 mvu_job_valid;
   logic                 mvu_job_ready;
   logic [HART_ID_W-1:0] mvu_job_hart;
   mvu_job_t             mvu_job;
   logic                 mvu_done;
   logic [HART_ID_W-1:0] mvu_done_hart;

   logic [CW-1:0] csr_mvu_wbaseaddr, csr_mvu_ibaseaddr, csr_mvu_obaseaddr,
      csr_mvu_wstride_0, csr_mvu_wstride_1, csr_mvu_wstride_2, csr_mvu_wstride_3,
      csr_mvu_istride_0, csr_mvu_istride_1, csr_mvu_istride_2, csr_mvu_istride_3,
      csr_mvu_ostride_0, csr_mvu_ostride_1, csr_mvu_ostride_2, csr_mvu_ostride_3,
      csr_mvu_wlength_0, csr_mvu_wlength_1, csr_mvu_wlength_2, csr_mvu_wlength_3,
      csr_mvu_ilength_0, csr_mvu_ilength_1, csr_mvu_ilength_2, csr_mvu_ilength_3,
      csr_mvu_olength_0, csr_mvu_olength_1, csr_mvu_olength_2, csr_mvu_olength_3,
      csr_mvu_precision, csr_mvu_command, csr_mvu_quant;

   modport master (
      output mvu_job_valid, mvu_job_hart, mvu_job,
      input  mvu_job_ready, mvu_done, mvu_done_hart,
      input  csr_mvu_wbaseaddr, csr_mvu_ibaseaddr, csr_mvu_obaseaddr,
      csr_mvu_wstride_0, csr_mvu_wstride_1, csr_mvu_wstride_2, csr_mvu_wstride_3,
      csr_mvu_istride_0, csr_mvu_istride_1, csr_mvu_istride_2, csr_mvu_istride_3,
      csr_mvu_ostride_0, csr_mvu_ostride_1, csr_mvu_ostride_2, csr_mvu_ostride_3,
      csr_mvu_wlength_0, csr_mvu_wlength_1, csr_mvu_wlength_2, csr_mvu_wlength_3,
      csr_mvu_ilength_0, csr_mvu_ilength_1, csr_mvu_ilength_2, csr_mvu_ilength_3,
      csr_mvu_olength_0, csr_mvu_olength_1, csr_mvu_olength_2, csr_mvu_olength_3,
      csr_mvu_precision, csr_mvu_command, csr_mvu_quant
   );

   modport slave (
      input  mvu_job_valid, mvu_job_hart, mvu_job,
      output mvu_job_ready, mvu_done, mvu_done_hart
   );

endinterface

// File: rtl/pito_mvu_dispatch_rr_arbiter.sv
// Round-robin request picker; pointer moves past the winner on each advance.
module pito_rr_arbiter
   import pito_mvu_dispatch_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_HARTS-1:0] req,
   input  logic                 advance,
   output logic [NUM_HARTS-1:0] gnt_c,
   output logic [HART_ID_W-1:0] gnt_idx_c,
   output logic                 gnt_any_c
);

   logic [HART_ID_W-1:0] ptr_q;
   logic [HART_ID_W-1:0] idx_c;

   // First requester at or above the pointer, wrapping around.
   always_comb begin
      gnt_c     = '0;
      gnt_idx_c = '0;
      gnt_any_c = 1'b0;
      idx_c     = '0;
      for (int unsigned i = 0; i < NUM_HARTS; i++) begin
         idx_c = HART_ID_W'((32'(ptr_q) + i) % NUM_HARTS);
         if (!gnt_any_c && req[idx_c]) begin
            gnt_any_c    = 1'b1;
            gnt_c[idx_c] = 1'b1;
            gnt_idx_c    = idx_c;
         end
      end
   end

   // Pointer update: next search starts just after the last winner.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ptr_q <= '0;
      else if (advance && gnt_any_c)
         ptr_q <= HART_ID_W'((32'(gnt_idx_c) + 32'd1) % NUM_HARTS);
   end

endmodule

// File: rtl/pito_mvu_dispatch.sv
// Per-hart MVU job slots, round-robin issue to the shared MVU, completion irqs.
module pito_mvu_dispatch
   import pito_mvu_dispatch_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   pito_mvu_dispatch_if.master    mvu,
   input  logic [NUM_HARTS-1:0]   mvu_start,
   output logic [NUM_HARTS-1:0]   mvu_irq_o,
   output logic [NUM_HARTS-1:0]   mvu_busy,
   output logic                   err_o
);

   mvu_slot_state_e      st_q [NUM_HARTS];
   mvu_slot_state_e      st_d [NUM_HARTS];
   mvu_job_t             slot_job_q [NUM_HARTS];
   mvu_job_t             csr_c [NUM_HARTS];
   logic [NUM_HARTS-1:0] snap_en_c, pend_c, done_vec_c, irq_d, gnt_c;
   logic [HART_ID_W-1:0] gnt_idx_c;
   logic                 gnt_any_c, load_c, err_d;
   logic                 valid_q;
   logic [HART_ID_W-1:0] hart_q;
   mvu_job_t             job_q;

   // Gather hart h's slice of every CSR bus into one job word.
   for (genvar h = 0; h < NUM_HARTS; h++) begin : g_csr
      localparam int unsigned LO = h * CSR_W;
      assign csr_c[h] = {
         mvu.csr_mvu_wbaseaddr[LO +: CSR_W], mvu.csr_mvu_ibaseaddr[LO +: CSR_W], mvu.csr_mvu_obaseaddr[LO +: CSR_W],
         mvu.csr_mvu_wstride_0[LO +: CSR_W], mvu.csr_mvu_wstride_1[LO +: CSR_W],
         mvu.csr_mvu_wstride_2[LO +: CSR_W], mvu.csr_mvu_wstride_3[LO +: CSR_W],
         mvu.csr_mvu_istride_0[LO +: CSR_W], mvu.csr_mvu_istride_1[LO +: CSR_W],
         mvu.csr_mvu_istride_2[LO +: CSR_W], mvu.csr_mvu_istride_3[LO +: CSR_W],
         mvu.csr_mvu_ostride_0[LO +: CSR_W], mvu.csr_mvu_ostride_1[LO +: CSR_W],
         mvu.csr_mvu_ostride_2[LO +: CSR_W], mvu.csr_mvu_ostride_3[LO +: CSR_W],
         mvu.csr_mvu_wlength_0[LO +: CSR_W], mvu.csr_mvu_wlength_1[LO +: CSR_W],
         mvu.csr_mvu_wlength_2[LO +: CSR_W], mvu.csr_mvu_wlength_3[LO +: CSR_W],
         mvu.csr_mvu_ilength_0[LO +: CSR_W], mvu.csr_mvu_ilength_1[LO +: CSR_W],
         mvu.csr_mvu_ilength_2[LO +: CSR_W], mvu.csr_mvu_ilength_3[LO +: CSR_W],
         mvu.csr_mvu_olength_0[LO +: CSR_W], mvu.csr_mvu_olength_1[LO +: CSR_W],
         mvu.csr_mvu_olength_2[LO +: CSR_W], mvu.csr_mvu_olength_3[LO +: CSR_W],
         mvu.csr_mvu_precision[LO +: CSR_W], mvu.csr_mvu_command[LO +: CSR_W], mvu.csr_mvu_quant[LO +: CSR_W]};
   end

   assign done_vec_c = mvu.mvu_done ? (NUM_HARTS'(1) << mvu.mvu_done_hart) : '0;
   assign load_c     = gnt_any_c && (!valid_q || mvu.mvu_job_ready);

   // Pending slots compete for the output register.
   always_comb begin
      pend_c = '0;
      for (int unsigned h = 0; h < NUM_HARTS; h++)
         pend_c[h] = (st_q[h] == PENDING);
   end

   pito_rr_arbiter u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (pend_c),
      .advance   (load_c),
      .gnt_c     (gnt_c),
      .gnt_idx_c (gnt_idx_c),
      .gnt_any_c (gnt_any_c)
   );

   // Slot state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned h = 0; h < NUM_HARTS; h++) st_q[h] <= IDLE;
      end else begin
         for (int unsigned h = 0; h < NUM_HARTS; h++) st_q[h] <= st_d[h];
      end
   end

   // Slot next-state, snapshot enables, irq and error detection.
   always_comb begin
      for (int unsigned h = 0; h < NUM_HARTS; h++) st_d[h] = st_q[h];
      snap_en_c = '0;
      irq_d     = '0;
      err_d     = 1'b0;
      for (int unsigned h = 0; h < NUM_HARTS; h++) begin
         case (st_q[h])
            IDLE: begin
               if (mvu_start[h]) begin
                  st_d[h]      = PENDING;
                  snap_en_c[h] = 1'b1;
               end
            end
            PENDING: begin
               if (load_c && gnt_c[h]) st_d[h] = ISSUED;
               if (mvu_start[h]) err_d = 1'b1;
            end
            ISSUED: begin
               if (done_vec_c[h]) begin
                  irq_d[h] = 1'b1;
                  // A start on the completing edge reuses the freed slot.
                  if (mvu_start[h]) begin
                     st_d[h]      = PENDING;
                     snap_en_c[h] = 1'b1;
                  end else begin
                     st_d[h] = IDLE;
                  end
               end else if (mvu_start[h]) begin
                  err_d = 1'b1;
               end
            end
            default: st_d[h] = IDLE;
         endcase
         if (done_vec_c[h] && (st_q[h] != ISSUED)) err_d = 1'b1;
      end
   end

   // Job snapshot taken on the accepted start edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned h = 0; h < NUM_HARTS; h++) slot_job_q[h] <= '0;
      end else begin
         for (int unsigned h = 0; h < NUM_HARTS; h++)
            if (snap_en_c[h]) slot_job_q[h] <= csr_c[h];
      end
   end

   // Output register: reloads when empty or draining, holds while stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         hart_q  <= '0;
         job_q   <= '0;
      end else if (load_c) begin
         valid_q <= 1'b1;
         hart_q  <= gnt_idx_c;
         job_q   <= slot_job_q[gnt_idx_c];
      end else if (mvu.mvu_job_ready) begin
         valid_q <= 1'b0;
      end
   end

   // Registered status: irq pulse, busy map, merged error pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mvu_irq_o <= '0;
         mvu_busy  <= '0;
         err_o     <= 1'b0;
      end else begin
         mvu_irq_o <= irq_d;
         err_o     <= err_d;
         for (int unsigned h = 0; h < NUM_HARTS; h++)
            mvu_busy[h] <= (st_d[h] != IDLE);
      end
   end

   assign mvu.mvu_job_valid = valid_q;
   assign mvu.mvu_job_hart  = hart_q;
   assign mvu.mvu_job       = job_q;

endmodule

// File: tb/tb_pito_mvu_dispatch.sv
// Randomized + directed bench for pito_mvu_dispatch with a job-level reference model.
module tb_pito_mvu_dispatch;
   import pito_mvu_dispatch_pkg::*;

   logic       clk, rst;
   logic [7:0] start;
   logic [7:0] irq, busy;
   logic       err;
   mvu_job_t   csr_tb [8];

   int errors = 0;
   int checks = 0;
   bit chk_en = 0;

   pito_mvu_dispatch_if cif ();

   pito_mvu_dispatch dut (
      .clk       (clk),
      .rst       (rst),
      .mvu       (cif),
      .mvu_start (start),
      .mvu_irq_o (irq),
      .mvu_busy  (busy),
      .err_o     (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Spread the per-hart CSR words across the flat buses.
   always_comb begin
      for (int h = 0; h < 8; h++) begin
         {cif.csr_mvu_wbaseaddr[h*32 +: 32], cif.csr_mvu_ibaseaddr[h*32 +: 32], cif.csr_mvu_obaseaddr[h*32 +: 32],
          cif.csr_mvu_wstride_0[h*32 +: 32], cif.csr_mvu_wstride_1[h*32 +: 32],
          cif.csr_mvu_wstride_2[h*32 +: 32], cif.csr_mvu_wstride_3[h*32 +: 32],
          cif.csr_mvu_istride_0[h*32 +: 32], cif.csr_mvu_istride_1[h*32 +: 32],
          cif.csr_mvu_istride_2[h*32 +: 32], cif.csr_mvu_istride_3[h*32 +: 32],
          cif.csr_mvu_ostride_0[h*32 +: 32], cif.csr_mvu_ostride_1[h*32 +: 32],
          cif.csr_mvu_ostride_2[h*32 +: 32], cif.csr_mvu_ostride_3[h*32 +: 32],
          cif.csr_mvu_wlength_0[h*32 +: 32], cif.csr_mvu_wlength_1[h*32 +: 32],
          cif.csr_mvu_wlength_2[h*32 +: 32], cif.csr_mvu_wlength_3[h*32 +: 32],
          cif.csr_mvu_ilength_0[h*32 +: 32], cif.csr_mvu_ilength_1[h*32 +: 32],
          cif.csr_mvu_ilength_2[h*32 +: 32], cif.csr_mvu_ilength_3[h*32 +: 32],
          cif.csr_mvu_olength_0[h*32 +: 32], cif.csr_mvu_olength_1[h*32 +: 32],
          cif.csr_mvu_olength_2[h*32 +: 32], cif.csr_mvu_olength_3[h*32 +: 32],
          cif.csr_mvu_precision[h*32 +: 32], cif.csr_mvu_command[h*32 +: 32],
          cif.csr_mvu_quant[h*32 +: 32]} = csr_tb[h];
      end
   end

   task automatic check(input string name, input logic [959:0] act, input logic [959:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: which harts wait, which are at the MVU, and what is on offer.
   bit       m_pend [8];
   bit       m_infl [8];
   mvu_job_t m_snap [8];
   int       m_ptr, m_hart, m_g, m_idx;
   bit       m_valid, m_err;
   mvu_job_t m_job;
   bit [7:0] m_irq, m_busy;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int h = 0; h < 8; h++) begin m_pend[h] = 0; m_infl[h] = 0; m_snap[h] = '0; end
         m_ptr = 0; m_valid = 0; m_hart = 0; m_job = '0; m_irq = 0; m_busy = 0; m_err = 0;
      end else begin
         m_irq = 0; m_err = 0; m_g = -1;
         // Winner chosen from jobs already waiting before this edge.
         if (!m_valid || cif.mvu_job_ready)
            for (int i = 0; i < 8; i++) begin
               m_idx = (m_ptr + i) % 8;
               if (m_g < 0 && m_pend[m_idx]) m_g = m_idx;
            end
         if (cif.mvu_done) begin
            if (m_infl[cif.mvu_done_hart]) begin
               m_infl[cif.mvu_done_hart] = 0;
               m_irq[cif.mvu_done_hart] = 1;
            end else m_err = 1;
         end
         for (int h = 0; h < 8; h++)
            if (start[h]) begin
               if (m_pend[h] || m_infl[h]) m_err = 1;
               else begin m_pend[h] = 1; m_snap[h] = csr_tb[h]; end
            end
         if (m_g >= 0) begin
            m_pend[m_g] = 0; m_infl[m_g] = 1;
            m_valid = 1; m_hart = m_g; m_job = m_snap[m_g];
            m_ptr = (m_g + 1) % 8;
         end else if (cif.mvu_job_ready) m_valid = 0;
         for (int h = 0; h < 8; h++) m_busy[h] = m_pend[h] | m_infl[h];
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en && !rst) begin
         check("valid", 960'(cif.mvu_job_valid), 960'(m_valid));
         if (m_valid) begin
            check("hart", 960'(cif.mvu_job_hart), 960'(m_hart));
            check("job", 960'(cif.mvu_job), 960'(m_job));
         end
         check("irq", 960'(irq), 960'(m_irq));
         check("busy", 960'(busy), 960'(m_busy));
         check("err", 960'(err), 960'(m_err));
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic done_pulse(input int h);
      cif.mvu_done = 1'b1; cif.mvu_done_hart = 3'(h);
      tick();
      cif.mvu_done = 1'b0;
   endtask

   task automatic start_pulse(input logic [7:0] s);
      start = s;
      tick();
      start = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   function automatic mvu_job_t rand_job();
      mvu_job_t j;
      for (int k = 0; k < 30; k++) j[k*32 +: 32] = $urandom;
      return j;
   endfunction

   mvu_job_t job_a;
   int       r_h;

   initial begin
      rst = 1'b1; start = '0;
      cif.mvu_job_ready = 1'b0; cif.mvu_done = 1'b0; cif.mvu_done_hart = '0;
      for (int h = 0; h < 8; h++) csr_tb[h] = '0;
      repeat (3) tick();
      rst = 1'b0; chk_en = 1;

      // Reset values.
      check("rst_valid", 960'(cif.mvu_job_valid), 960'(0));
      check("rst_hart", 960'(cif.mvu_job_hart), 960'(0));
      check("rst_job", 960'(cif.mvu_job), 960'(0));
      check("rst_busy", 960'(busy), 960'(0));
      check("rst_irq_err", 960'({irq, err}), 960'(0));

      // Single job, ready high: offered two edges after the start.
      cif.mvu_job_ready = 1'b1;
      csr_tb[2].wbaseaddr = 32'h100; csr_tb[2].command = 32'h1;
      start_pulse(8'h04);
      check("t1_busy2", 960'(busy[2]), 960'(1));
      check("t1_valid_early", 960'(cif.mvu_job_valid), 960'(0));
      tick();
      check("t1_valid", 960'(cif.mvu_job_valid), 960'(1));
      check("t1_hart", 960'(cif.mvu_job_hart), 960'(2));
      check("t1_wbase", 960'(cif.mvu_job.wbaseaddr), 960'(32'h100));
      check("t1_cmd", 960'(cif.mvu_job.command), 960'(32'h1));
      tick();
      check("t1_drained", 960'(cif.mvu_job_valid), 960'(0));
      done_pulse(2);
      check("t1_irq", 960'(irq), 960'(8'b0000_0100));
      check("t1_busy_clr", 960'(busy[2]), 960'(0));
      tick();
      check("t1_irq_once", 960'(irq), 960'(0));

      // Round-robin from pointer 0: 0,3,5.
      do_reset();
      cif.mvu_job_ready = 1'b1;
      start_pulse(8'b0010_1001);
      tick(); check("rr0_a", 960'(cif.mvu_job_hart), 960'(0));
      tick(); check("rr0_b", 960'(cif.mvu_job_hart), 960'(3));
      tick(); check("rr0_c", 960'(cif.mvu_job_hart), 960'(5));
      tick(); check("rr0_empty", 960'(cif.mvu_job_valid), 960'(0));
      done_pulse(0); done_pulse(3); done_pulse(5);
      // Move pointer to 4 via a lone grant to hart 3, then 5,0,3.
      start_pulse(8'h08); tick(); tick(); done_pulse(3);
      start_pulse(8'b0010_1001);
      tick(); check("rr4_a", 960'(cif.mvu_job_hart), 960'(5));
      tick(); check("rr4_b", 960'(cif.mvu_job_hart), 960'(0));
      tick(); check("rr4_c", 960'(cif.mvu_job_hart), 960'(3));
      tick(); done_pulse(5); done_pulse(0); done_pulse(3);

      // Stall: job held stable and carries the start-time snapshot.
      cif.mvu_job_ready = 1'b0;
      for (int k = 0; k < 30; k++) job_a[k*32 +: 32] = 32'hA000_0000 + 32'(k);
      csr_tb[7] = job_a;
      start_pulse(8'h80);
      csr_tb[7] = ~job_a;
      tick();
      for (int c = 0; c < 10; c++) begin
         check("stall_valid", 960'(cif.mvu_job_valid), 960'(1));
         check("stall_hart", 960'(cif.mvu_job_hart), 960'(7));
         check("stall_job", 960'(cif.mvu_job), 960'(job_a));
         tick();
      end
      cif.mvu_job_ready = 1'b1;
      tick();
      check("stall_drained", 960'(cif.mvu_job_valid), 960'(0));
      done_pulse(7);

      // Restart while ISSUED, then done for an idle hart.
      start_pulse(8'h02); tick(); tick();
      start_pulse(8'h02);
      check("dup_err", 960'(err), 960'(1));
      tick();
      check("dup_err_once", 960'(err), 960'(0));
      check("dup_no_job", 960'(cif.mvu_job_valid), 960'(0));
      done_pulse(1); tick();
      done_pulse(6);
      check("idle_done_err", 960'(err), 960'(1));
      check("idle_done_irq", 960'(irq), 960'(0));
      tick();

      // Done and start on the same edge for hart 4.
      start_pulse(8'h10); tick(); tick();
      start = 8'h10; cif.mvu_done = 1'b1; cif.mvu_done_hart = 3'd4;
      tick();
      start = '0; cif.mvu_done = 1'b0;
      check("same_irq", 960'(irq), 960'(8'h10));
      check("same_err", 960'(err), 960'(0));
      check("same_busy", 960'(busy[4]), 960'(1));
      tick();
      check("same_reissue", 960'(cif.mvu_job_valid), 960'(1));
      check("same_hart", 960'(cif.mvu_job_hart), 960'(4));
      tick(); done_pulse(4); tick();

      // Reset in the middle of a stalled handshake.
      cif.mvu_job_ready = 1'b0;
      start_pulse(8'h04); tick();
      check("mid_valid_pre", 960'(cif.mvu_job_valid), 960'(1));
      #2 rst = 1'b1;
      #1;
      check("mid_valid_rst", 960'(cif.mvu_job_valid), 960'(0));
      check("mid_busy_rst", 960'(busy), 960'(0));
      check("mid_irq_rst", 960'(irq), 960'(0));
      tick();
      rst = 1'b0;
      done_pulse(2);
      check("mid_late_done_err", 960'(err), 960'(1));
      tick();

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         cif.mvu_job_ready = ($urandom_range(0, 9) < 7);
         for (int h = 0; h < 8; h++) begin
            start[h] = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 3) == 0) csr_tb[h] = rand_job();
         end
         cif.mvu_done = 1'b0;
         if ($urandom_range(0, 2) == 0) begin
            r_h = int'($urandom_range(0, 7));
            if (m_infl[r_h] || $urandom_range(0, 15) == 0) begin
               cif.mvu_done = 1'b1; cif.mvu_done_hart = 3'(r_h);
            end
         end
         tick();
      end
      start = '0; cif.mvu_done = 1'b0; cif.mvu_job_ready = 1'b1;
      repeat (5) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pito_mvu_dispatch.md
Name: pito_mvu_dispatch

Overview:
- Sits directly downstream of the pito core's per-hart MVU CSR outputs and upstream of the shared MVU job port.
- On each hart's mvu_start pulse it snapshots that hart's CSR configuration into a job slot.
- It issues pending jobs to the MVU over a valid/ready handshake using round-robin arbitration, tracks completion per hart, and returns a one-cycle interrupt to the issuing hart.
- Its interrupt output feeds the core's mvu_irq_i.

Parameters:
- NUM_HARTS, 8, number of hart slots; equals `PITO_NUM_HARTS.
- CSR_W, 32, width of one CSR field.
- HART_ID_W, $clog2(NUM_HARTS), width of hart index.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- csr_mvu_wbaseaddr..csr_mvu_quant  input  CSR_W*NUM_HARTS each  30 per-hart CSR fields: wbaseaddr, ibaseaddr, obaseaddr, {w,i,o}stride_0..3, {w,i,o}length_0..3, precision, command, quant. Hart h occupies bits [CSR_W*h+CSR_W-1 : CSR_W*h].
- mvu_start  input  NUM_HARTS  per-hart single-cycle job start request.
- mvu_job_valid  output  1  job offered to the MVU.
- mvu_job_ready  input  1  MVU accepts the job.
- mvu_job_hart  output  HART_ID_W  hart that owns the offered job.
- mvu_job  output  $bits(mvu_job_t) (960)  snapshot of the 30 fields.
- mvu_done  input  1  MVU job-complete pulse.
- mvu_done_hart  input  HART_ID_W  hart whose job completed.
- mvu_irq_o  output  NUM_HARTS  one-cycle completion interrupt, to mvu_irq_i.
- mvu_busy  output  NUM_HARTS  slot is not IDLE.
- err_o  output  1  one-cycle protocol-error pulse.

Behaviour:
- Reset:
  - Asynchronous; all slots go to IDLE and the RR pointer goes to 0.
  - mvu_job_valid, mvu_irq_o, mvu_busy and err_o go to 0.
  - mvu_job and mvu_job_hart go to 0.
- Per-hart slot FSM:
  - IDLE -> PENDING on mvu_start[h]. The CSR fields are latched into the slot on that same edge; later CSR changes do not affect the job.
  - PENDING -> ISSUED when the arbiter loads slot h into the output register.
  - ISSUED -> IDLE on mvu_done with mvu_done_hart==h. mvu_irq_o[h] pulses high for exactly the next cycle.
- Start while not IDLE: the request is dropped and err_o pulses.
- Start and done for the same hart on the same edge: done completes the slot, irq pulses, and start is accepted (slot goes to PENDING with the new snapshot). No error.
- Output register:
  - It may load when it is empty or being drained that edge (valid & ready), so back-to-back jobs run with no bubble.
  - The loaded job comes from the first PENDING slot found scanning from the RR pointer upward, with wrap-around.
  - After a grant to h, the pointer becomes (h+1) mod NUM_HARTS.
- Handshake:
  - While valid & !ready, mvu_job and mvu_job_hart are held stable and valid is not deasserted.
  - The transfer occurs on an edge with valid & ready.
- Latency: start sampled at edge k -> slot PENDING after k -> mvu_job_valid high after edge k+1 at the earliest (2 cycles).
- Capacity: at most one job per hart in flight. Completions may return in any order.
- Done for a hart whose slot is not ISSUED (including after a reset mid-job): ignored, err_o pulses.
- Simultaneous errors in one cycle produce a single err_o pulse.
- mvu_busy[h] = (slot[h] != IDLE), registered.

Decomposition:
- pito_pkg gains:
  - mvu_job_t, a packed struct of the 30 CSR_W fields in the listed order, with wbaseaddr at the MSB end.
  - mvu_slot_state_e {IDLE, PENDING, ISSUED}.
  - MVU_JOB_W constant.
- One sub-module, pito_rr_arbiter: NUM_HARTS request vector plus an advance strobe -> one-hot grant and index. It holds the rotating pointer.

Test Plan:
- Hart 2 starts with wbaseaddr=0x100, command=0x1, ready tied high -> valid in cycle k+2 with hart=2 and matching fields. Done(hart 2) -> mvu_irq_o=8'b0000_0100 for one cycle and busy[2]=0.
- Harts 0, 3 and 5 start on the same cycle with ready high -> issue order 0,3,5 on consecutive cycles. Repeat with the pointer at 4 -> order 5,0,3.
- ready held low for 10 cycles while a job is valid -> mvu_job and hart stable. The CSR inputs are changed after start -> the issued job still carries the snapshot values.
- Hart 1 issues a second start while ISSUED -> err_o pulses once and no second job appears. Done(hart 6) while hart 6 is IDLE -> err_o pulses and irq stays 0.
- Same-edge done(hart 4) and start[4] -> irq[4] pulses, slot goes to PENDING, a new job is issued, err_o=0.
- rst asserted mid-handshake (valid=1, ready=0) -> valid, busy and irq go to 0 immediately. A later done for that hart -> err_o pulses.
